// File: rtl/raw_pixel_unpacker.sv
// CSI-2 long-packet payload unpacker: RAW8/RAW10/RAW12 bytes in, four 16-bit pixels per beat out.
// Accepts LANES bytes per cycle and flags the first group of each line and truncated lines.
module raw_pixel_unpacker #(
  parameter int unsigned LANES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8*LANES-1:0] din,
  input  logic               frame_active,
  input  logic               frame_valid,
  input  logic [1:0]         mode,
  output logic [63:0]        dout,
  output logic               valid,
  output logic               first,
  output logic               line_err
);

  localparam logic [3:0] LanesW = 4'(LANES);

  typedef enum logic [1:0] {ModeRaw8, ModeRaw10, ModeRaw12, ModeRsvd} mode_e;

  logic [7:0]  buf_q [10];
  logic [7:0]  buf_d [10];
  logic [7:0]  cat   [10];
  logic [3:0]  occ_q, occ_d;
  mode_e       mode_q, mode_d;
  logic        fp_q, fp_d;
  logic        fa_q, fa_d;
  logic        line_on_q, line_on_d;
  logic [63:0] dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic        line_err_q, line_err_d;

  logic        start;
  logic        line_act;
  mode_e       mode_eff;
  logic [3:0]  base;
  logic [3:0]  occ_new;
  logic [3:0]  grp;
  logic [3:0]  idx;
  logic        fp_eff;
  logic [15:0] pix [4];

  always_comb begin
    start    = frame_active && !fa_q;
    line_act = frame_active && (line_on_q || start);
    mode_eff = start ? mode_e'(mode) : mode_q;
    base     = start ? 4'd0 : occ_q;
    fp_eff   = start ? 1'b1 : fp_q;

    unique case (mode_eff)
      ModeRaw10: grp = 4'd5;
      ModeRaw12: grp = 4'd6;
      default:   grp = 4'd4;
    endcase

    for (int k = 0; k < 10; k++) begin
      cat[k] = start ? 8'h00 : buf_q[k];
    end

    occ_new   = base;
    idx       = 4'd0;
    fa_d      = frame_active;
    line_on_d = frame_active && (line_on_q || start);
    mode_d    = mode_eff;
    fp_d      = fp_eff;
    occ_d     = base;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    first_d   = 1'b0;
    line_err_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix[i] = 16'h0000;
    end

    if (line_act && frame_valid && (mode_eff != ModeRsvd)) begin
      for (int j = 0; j < int'(LANES); j++) begin
        idx      = base + 4'(j);
        cat[idx] = din[8*j +: 8];
      end
      occ_new = base + LanesW;
    end

    unique case (mode_eff)
      ModeRaw10: begin
        for (int i = 0; i < 4; i++) begin
          pix[i] = {6'd0, cat[i], cat[4][2*i +: 2]};
        end
      end
      ModeRaw12: begin
        pix[0] = {4'd0, cat[0], cat[2][3:0]};
        pix[1] = {4'd0, cat[1], cat[2][7:4]};
        pix[2] = {4'd0, cat[3], cat[5][3:0]};
        pix[3] = {4'd0, cat[4], cat[5][7:4]};
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          pix[i] = {8'd0, cat[i]};
        end
      end
    endcase

    for (int k = 0; k < 10; k++) begin
      buf_d[k] = cat[k];
    end

    if (line_act && frame_valid && (mode_eff != ModeRsvd)) begin
      occ_d = occ_new;
      if (occ_new >= grp) begin
        dout_d  = {pix[3], pix[2], pix[1], pix[0]};
        valid_d = 1'b1;
        first_d = fp_eff;
        fp_d    = 1'b0;
        occ_d   = occ_new - grp;
        for (int k = 0; k < 10; k++) begin
          idx      = 4'(k) + grp;
          buf_d[k] = (idx < 4'd10) ? cat[idx] : 8'h00;
        end
      end
    end

    // Leaving a line drops any partial group; only a started line can hold bytes.
    if (!frame_active) begin
      occ_d      = 4'd0;
      line_err_d = fa_q && (occ_q != 4'd0);
      for (int k = 0; k < 10; k++) begin
        buf_d[k] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 10; k++) begin
        buf_q[k] <= 8'h00;
      end
      occ_q      <= 4'd0;
      mode_q     <= ModeRaw8;
      fp_q       <= 1'b1;
      // Held high so a line already active at release is never seen as a line start.
      fa_q       <= 1'b1;
      line_on_q  <= 1'b0;
      dout_q     <= 64'd0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < 10; k++) begin
        buf_q[k] <= buf_d[k];
      end
      occ_q      <= occ_d;
      mode_q     <= mode_d;
      fp_q       <= fp_d;
      fa_q       <= fa_d;
      line_on_q  <= line_on_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      line_err_q <= line_err_d;
    end
  end

  assign dout     = dout_q;
  assign valid    = valid_q;
  assign first    = first_q;
  assign line_err = line_err_q;

endmodule

// File: doc/raw_pixel_unpacker.md
Name: raw_pixel_unpacker

Overview:
- Parametrised successor to the fixed RAW10, two-lane CSI-2 payload decoder.
- Accepts LANES bytes per cycle of CSI-2 long-packet payload.
- Unpacks RAW8, RAW10 or RAW12 (mode selected per line) into four zero-extended 16-bit pixels per output beat.
- Sits between the lane aligner/packet parser and the pixel buffer/DMA.
- Also flags the first beat of each line and truncated lines.

Parameters:
- LANES, 2, payload bytes per cycle; legal values 1, 2, 4. din width = 8*LANES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- din  input  8*LANES  payload bytes; din[7:0] is the earliest byte, din[8k+7:8k] is byte k
- frame_active  input  1  high for the duration of a line's payload; low between packets
- frame_valid  input  1  din qualifier; bytes are consumed only when frame_active && frame_valid
- mode  input  2  0=RAW8, 1=RAW10, 2=RAW12, 3=reserved; sampled on the first active cycle of a line
- dout  output  64  pixel i at dout[16i+15:16i], i=0 earliest; value LSB-aligned, upper bits zero
- valid  output  1  dout qualifier, one-cycle pulse per group
- first  output  1  high with valid on the first group of a line
- line_err  output  1  one-cycle pulse: line ended with a partial group buffered

Behaviour:
- Reset (reset=0, async): dout=0, valid=0, first=0, line_err=0, byte buffer and occupancy count cleared, latched mode=0, first-pending flag set.
- Line start: on a cycle where frame_active=1 and the previous-cycle frame_active=0:
  - latch mode;
  - set the first-pending flag;
  - occupancy starts at 0.
  - mode changes mid-line are ignored.
- Group size G by latched mode:
  - RAW8 = 4 bytes.
  - RAW10 = 5 bytes. B0..B3 are P0..P3 bits[9:2]. B4 bits[1:0]=P0[1:0], [3:2]=P1, [5:4]=P2, [7:6]=P3.
  - RAW12 = 6 bytes. B0=P0[11:4], B1=P1[11:4]. B2[3:0]=P0[3:0], B2[7:4]=P1[3:0]. B3, B4, B5 map identically for P2, P3.
- Byte buffer holds 10 bytes. Each consuming cycle appends LANES bytes after the existing occupancy.
- If occupancy after append ≥ G:
  - unpack the oldest G bytes;
  - register dout, valid=1 and first=first-pending on the next rising edge (latency 1 cycle from the completing beat);
  - shift out G bytes and clear first-pending.
- At most one group completes per cycle, since LANES ≤ G. Maximum occupancy before append is G-1 ≤ 5; after append it is ≤ 9.
- valid=0 on every cycle with no completed group. dout holds its last value when valid=0.
- frame_valid=0 while frame_active=1: nothing appended, buffer held.
- frame_active=0: din and frame_valid ignored. On the first cycle with frame_active=0:
  - if occupancy ≠ 0, pulse line_err for one cycle and discard the bytes;
  - occupancy forced to 0.
- A group completing on the last active beat is still emitted. It is not an error.
- Mode 3: bytes consumed and discarded. valid never asserts. line_err never asserts for that line.
- Back-to-back lines with a single idle cycle between them are supported; the buffer is clean at the next line start.
- Reset asserted mid-line: immediate clear per above. After release, decoding resumes only at the next frame_active rising edge; a line already active at release is ignored until frame_active falls.

Test Plan:
- RAW10, LANES=2, din 0x0201, 0x0403, then 0x55E4 → one cycle later valid=1, first=1, dout=0x0013_000E_0009_0004. Byte 0x55 remains buffered.
- RAW8, LANES=2, din 0x2211, 0x4433 → dout=0x0044_0033_0022_0011, valid=1 with first=1. Next group 0x6655, 0x8877 → dout=0x0088_0077_0066_0055, first=0.
- RAW12, LANES=2, bytes AB CD 21 12 34 65 → dout=0x0346_0125_0CD2_0AB1, valid exactly one pulse.
- Repeat the RAW10 case with frame_valid=0 idle cycles between beats → identical dout; valid delayed by the gap count; no spurious pulses.
- RAW10, 7 bytes, then frame_active falls → one valid group, then line_err pulse one cycle after the fall. The next line's first group carries first=1 and correct pixels.
- Reset pulled low mid-group, then released mid-line → all outputs 0 immediately; no valid until the following line. Also run the RAW10 case with LANES=1 and LANES=4 and check identical dout.
